// File: rtl/mod_seq_ctrl_if.sv
// Control/config/status bundle for the multi-modulus sequencer.
interface mod_seq_ctrl_if #(
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = $clog2(DEPTH)
);
    logic              cfg_we;
    logic [SLOT_W-1:0] cfg_addr;
    logic [CNT_W-1:0]  cfg_mod;
    logic              len_we;
    logic [SLOT_W:0]   cfg_len;
    logic              start;
    logic              stop;
    logic              loop;
    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [SLOT_W-1:0] slot;
    logic              slot_end;
    logic              done;
    logic              err;

    modport master (
        output cfg_we, cfg_addr, cfg_mod, len_we, cfg_len,
        output start, stop, loop,
        input  busy, cnt, slot, slot_end, done, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mod, len_we, cfg_len,
        input  start, stop, loop,
        output busy, cnt, slot, slot_end, done, err
    );
endinterface

// File: rtl/mod_seq_ctrl.sv
// Multi-modulus sequencer: steps one counter through a table of moduli.
// Optional sticky config-error detection enabled by MOD_SEQ_ERR_EN.
module mod_seq_ctrl #(
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    mod_seq_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SLOT_W:0] DEPTH_L = (SLOT_W+1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  mod_q [DEPTH];
    logic [SLOT_W:0]   len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic              done_q;
    logic              done_d;
    logic              busy;
    logic              slot_end;
    logic [SLOT_W:0]   len_eff;
    logic [SLOT_W-1:0] last_slot;
    logic [CNT_W-1:0]  lim;
    logic              at_end;
    logic              last;
    logic              idle;
    logic              mod_acc;
    logic              len_acc;

    assign idle = (state_q == IDLE);

    // len of 0 or beyond the table both mean "use every slot"
    always_comb begin
        len_eff = len_q;
        if (len_q == '0 || len_q > DEPTH_L)
            len_eff = DEPTH_L;
    end

    assign last_slot = SLOT_W'(len_eff - 1'b1);
    // m=0 wraps at all-ones, m=1 compares against 0
    assign lim       = mod_q[slot_q] - 1'b1;
    assign at_end    = (cnt_q == lim);
    assign last      = (slot_q == last_slot);

`ifdef MOD_SEQ_ERR_EN
    logic mod_ok;
    logic len_ok;
    logic err_q;
    logic err_set;

    assign mod_ok  = (bus.cfg_mod > CNT_W'(1));
    assign len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= DEPTH_L);
    assign mod_acc = bus.cfg_we && mod_ok;
    assign len_acc = bus.len_we && len_ok;
    assign err_set = idle ? ((bus.cfg_we && !mod_ok) ||
                             (bus.len_we && !len_ok))
                          : (bus.cfg_we || bus.len_we);

    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign mod_acc = bus.cfg_we;
    assign len_acc = bus.len_we;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mod_q[i] <= CNT_W'(2);
            mod_q[0] <= CNT_W'(5);
            mod_q[1] <= CNT_W'(3);
            mod_q[2] <= CNT_W'(6);
            len_q    <= (SLOT_W+1)'(3);
        end else if (idle) begin
            if (mod_acc)
                mod_q[bus.cfg_addr] <= bus.cfg_mod;
            if (len_acc)
                len_q <= bus.cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop)
                    state_d = RUN;
            end
            RUN: begin
                if (bus.stop)
                    state_d = IDLE;
                else if (at_end && last && !bus.loop)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == RUN);
        slot_end = busy && at_end;
        cnt_d    = '0;
        slot_d   = '0;
        done_d   = 1'b0;
        if (busy && !bus.stop) begin
            if (!at_end) begin
                cnt_d  = cnt_q + 1'b1;
                slot_d = slot_q;
            end else if (!last) begin
                slot_d = slot_q + 1'b1;
            end else begin
                done_d = !bus.loop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            slot_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            done_q <= done_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.cnt      = cnt_q;
    assign bus.slot     = slot_q;
    assign bus.slot_end = slot_end;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Scoreboard bench for mod_seq_ctrl: stimulus queues expected cycles,
// a negedge monitor pops and compares.
module tb_mod_seq_ctrl;
    typedef struct packed {
        logic [7:0] tag;
        logic       busy;
        logic [3:0] cnt;
        logic [1:0] slot;
        logic       se;
        logic       done;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   checks;
    int   errors;
    int   tag;
    logic exp_err;

    int dc[14] = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 3, 4, 5};
    int ds[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2};
    int de[14] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int lc[9]  = '{0, 1, 0, 1, 2, 3, 4, 5, 6};
    int ls[9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    int le[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};

    mod_seq_ctrl_if #(.CNT_W(4), .DEPTH(4)) bus ();

    mod_seq_ctrl #(.CNT_W(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic b, input int c, input int s,
                        input logic se, input logic d);
        exp_t e;
        @(posedge clk);
        #1;
        e.tag  = tag[7:0];
        e.busy = b;
        e.cnt  = c[3:0];
        e.slot = s[1:0];
        e.se   = se;
        e.done = d;
        e.err  = exp_err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.busy !== e.busy || bus.cnt !== e.cnt ||
                bus.slot !== e.slot || bus.slot_end !== e.se ||
                bus.done !== e.done || bus.err !== e.err) begin
                errors++;
                $display("FAIL test%0d b/c/s/se/d/e got %b/%0d/%0d/%b/%b/%b want %b/%0d/%0d/%b/%b/%b",
                         e.tag, bus.busy, bus.cnt, bus.slot, bus.slot_end,
                         bus.done, bus.err, e.busy, e.cnt, e.slot, e.se,
                         e.done, e.err);
            end
        end
    end

    task automatic run_default();
        bus.start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, dc[i], ds[i], de[i] != 0, 1'b0);
            if (i == 0) bus.start = 1'b0;
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input int a, input int m);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a[1:0];
        bus.cfg_mod  = m[3:0];
        step(1'b0, 0, 0, 1'b0, 1'b0);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic setlen(input int l);
        bus.len_we  = 1'b1;
        bus.cfg_len = l[2:0];
        step(1'b0, 0, 0, 1'b0, 1'b0);
        bus.len_we  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_err  = 1'b0;
        tag      = 0;
        rst      = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_mod = '0;
        bus.len_we = 1'b0; bus.cfg_len = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b0);

        tag = 1;
        run_default();

        tag = 2;
        cfg(0, 2);
        cfg(1, 7);
        setlen(2);
        bus.loop  = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 27; i++) begin
            if (i >= 19) bus.loop = 1'b0;
            step(1'b1, lc[i % 9], ls[i % 9], le[i % 9] != 0, 1'b0);
            if (i == 0) bus.start = 1'b0;
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);

        tag = 6;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, lc[i], ls[i], le[i] != 0, 1'b0);
            if (i == 0) bus.start = 1'b0;
        end
        rst = 1'b0;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        tag = 7;
        run_default();

        tag = 3;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, dc[i], 0, 1'b0, 1'b0);
            if (i == 0) bus.start = 1'b0;
        end
        bus.stop = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        bus.stop = 1'b0;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        tag = 4;
        bus.start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'd0;
                bus.cfg_mod  = 4'd9;
`ifdef MOD_SEQ_ERR_EN
                exp_err = 1'b1;
`endif
            end
            step(1'b1, dc[i], ds[i], de[i] != 0, 1'b0);
            if (i == 0) bus.start = 1'b0;
            if (i == 2) bus.cfg_we = 1'b0;
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);

        tag = 5;
`ifndef MOD_SEQ_ERR_EN
        cfg(0, 1);
        cfg(1, 0);
        setlen(2);
        bus.start = 1'b1;
        step(1'b1, 0, 0, 1'b1, 1'b0);
        bus.start = 1'b0;
        for (int k = 0; k < 16; k++)
            step(1'b1, k, 1, k == 15, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
`else
        cfg(0, 1);
        setlen(0);
        run_default();
`endif

        for (int k = 0; k < 4 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
